// File: rtl/reg_dump_reader_pkg.sv
// Shared types and widths for the register dump reader.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (adds a trailing XOR checksum beat).
package regdump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // CSUM is only reachable when REG_DUMP_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND_A,
    SEND_B,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Register-file read port pair plus the outgoing beat stream of the dump reader.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (no effect on this interface).
interface reg_dump_reader_if;
  import regdump_pkg::*;

  logic [REG_ADDR_W-1:0] read_reg1;
  logic [REG_ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0]     read_data1;
  logic [DATA_W-1:0]     read_data2;
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] out_index;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;

  // The reader drives addresses and the stream; the register file and sink answer.
  modport master (
    output read_reg1, read_reg2, out_valid, out_index, out_data, out_last,
    input  read_data1, read_data2, out_ready
  );

  modport slave (
    input  read_reg1, read_reg2, out_valid, out_index, out_data, out_last,
    output read_data1, read_data2, out_ready
  );

endinterface

// File: rtl/reg_dump_reader_csum.sv
// XOR accumulator folding every accepted data beat into a running checksum.
// Only instantiated when REG_DUMP_CHECKSUM_EN is defined.
module regdump_csum
  import regdump_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sum
);

  // Clear wins over enable so a fresh dump always starts from zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Register dump reader: reads a register file two words at a time and streams
// each word as a valid/ready beat tagged with its register number.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module reg_dump_reader
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  output logic               busy,
  output logic               done,
  reg_dump_reader_if.master  bus
);

  // Pair counter fits in the address width minus the even/odd bit.
  localparam int            K_W    = REG_ADDR_W - 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_REGS / 2 - 1);

  state_t            state_reg;
  logic [K_W-1:0]    k_reg;
  logic [K_W-1:0]    k_next;
  logic [DATA_W-1:0] buf_a_reg;
  logic [DATA_W-1:0] buf_b_reg;

  assign k_next = k_reg + 1'b1;

`ifdef REG_DUMP_CHECKSUM_EN
  logic              csum_clear;
  logic              csum_enable;
  logic [DATA_W-1:0] csum_value;

  assign csum_clear  = (state_reg == IDLE) && start;
  assign csum_enable = bus.out_valid && bus.out_ready &&
                       ((state_reg == SEND_A) || (state_reg == SEND_B));

  regdump_csum u_csum (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (csum_clear),
    .enable (csum_enable),
    .data   (bus.out_data),
    .sum    (csum_value)
  );
`endif

  // Beat data comes straight from the capture buffers, so it cannot move during a stall.
  always_comb begin
    bus.out_data = buf_a_reg;
    if (state_reg == SEND_B) begin
      bus.out_data = buf_b_reg;
    end
`ifdef REG_DUMP_CHECKSUM_EN
    else if (state_reg == CSUM) begin
      bus.out_data = csum_value;
    end
`endif
  end

  // Dump sequencer: control outputs are registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      buf_a_reg     <= '0;
      buf_b_reg     <= '0;
      bus.read_reg1 <= '0;
      bus.read_reg2 <= '0;
      bus.out_valid <= 1'b0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            k_reg         <= '0;
            bus.read_reg1 <= '0;
            bus.read_reg2 <= REG_ADDR_W'(1);
            busy          <= 1'b1;
            state_reg     <= READ;
          end
        end
        READ: begin
          buf_a_reg     <= bus.read_data1;
          buf_b_reg     <= bus.read_data2;
          bus.out_valid <= 1'b1;
          bus.out_index <= {k_reg, 1'b0};
          bus.out_last  <= 1'b0;
          state_reg     <= SEND_A;
        end
        SEND_A: begin
          if (bus.out_ready) begin
            bus.out_index <= {k_reg, 1'b1};
`ifdef REG_DUMP_CHECKSUM_EN
            bus.out_last  <= 1'b0;
`else
            bus.out_last  <= (k_reg == K_LAST);
`endif
            state_reg     <= SEND_B;
          end
        end
        SEND_B: begin
          if (bus.out_ready) begin
            if (k_reg != K_LAST) begin
              k_reg         <= k_next;
              bus.read_reg1 <= {k_next, 1'b0};
              bus.read_reg2 <= {k_next, 1'b1};
              bus.out_valid <= 1'b0;
              state_reg     <= READ;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              bus.out_index <= '0;
              bus.out_last  <= 1'b1;
              state_reg     <= CSUM;
`else
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              done          <= 1'b1;
              state_reg     <= DONE;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            done          <= 1'b1;
            state_reg     <= DONE;
          end
        end
`endif
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed testbench for reg_dump_reader with a behavioural register file.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (enables the checksum-beat test).
module tb_reg_dump_reader;
  import regdump_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int NBEATS   = 33;
  localparam int DONE_LAT = 49;  // 16 pairs x 3 cycles + checksum beat
`else
  localparam int NBEATS   = 32;
  localparam int DONE_LAT = 48;  // 16 pairs x 3 cycles
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  reg_dump_reader_if bus ();

  reg_dump_reader #(.NUM_REGS(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Register file model with combinational read ports
  logic [31:0] regs     [0:31];
  logic [31:0] exp_regs [0:31];
  assign bus.read_data1 = regs[bus.read_reg1];
  assign bus.read_data2 = regs[bus.read_reg2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Beat monitor, stall stability and done pulse counting
  logic [4:0]  mon_idx  [$];
  logic [31:0] mon_data [$];
  logic        mon_last [$];
  int          done_count = 0;
  int          done_cyc   = 0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_idx   = '0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("stall_valid", 32'(bus.out_valid), 32'd1);
        check_val("stall_index", 32'(bus.out_index), 32'(prev_idx));
        check_val("stall_data", bus.out_data, prev_data);
        check_val("stall_last", 32'(bus.out_last), 32'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        mon_idx.push_back(bus.out_index);
        mon_data.push_back(bus.out_data);
        mon_last.push_back(bus.out_last);
      end
      if (done) begin
        done_count <= done_count + 1;
        done_cyc   <= cyc;
      end
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_idx   <= bus.out_index;
      prev_data  <= bus.out_data;
      prev_last  <= bus.out_last;
    end
  end

  // Sink ready pattern: 0 = always ready, 1 = toggle, 2 = stall on index 13
  int rdy_mode = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = !(bus.out_valid && (bus.out_index == 5'd13));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      regs[i]     = 32'(i) * 32'h11111111;
      exp_regs[i] = regs[i];
    end
  endtask

  task automatic clear_mon();
    mon_idx.delete();
    mon_data.delete();
    mon_last.delete();
  endtask

  task automatic pulse_start(output int read_cyc);
    @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    read_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int base);
    for (int i = 0; i < 3000 && done_count == base; i++) @(posedge CLK);
    check_val({tag, "_done_seen"}, 32'(done_count != base), 32'd1);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 2000 && mon_idx.size() < n; i++) @(posedge CLK);
    check_val("beats_reached", 32'(mon_idx.size() >= n), 32'd1);
  endtask

  task automatic verify_dump(input string tag);
    logic [31:0] x;
    logic [4:0]  eidx;
    logic [31:0] edata;
    x = '0;
    check_val({tag, "_count"}, 32'(mon_idx.size()), 32'(NBEATS));
    for (int i = 0; i < NBEATS && i < mon_idx.size(); i++) begin
      if (i < 32) begin
        eidx  = 5'(i);
        edata = exp_regs[i];
        x     = x ^ exp_regs[i];
      end else begin
        eidx  = 5'd0;
        edata = x;
      end
      check_val($sformatf("%s_idx%0d", tag, i), 32'(mon_idx[i]), 32'(eidx));
      check_val($sformatf("%s_data%0d", tag, i), mon_data[i], edata);
      check_val($sformatf("%s_last%0d", tag, i), 32'(mon_last[i]), 32'(i == NBEATS - 1));
    end
    $display("dump %s: %0d beats captured, done pulses so far %0d", tag, mon_idx.size(), done_count);
  endtask

  initial begin
    int rc;
    int base;

    preload();
    #2 RST_N = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_last", 32'(bus.out_last), 32'd0);
    check_val("rst_index", 32'(bus.out_index), 32'd0);
    check_val("rst_data", bus.out_data, 32'd0);
    check_val("rst_rreg1", 32'(bus.read_reg1), 32'd0);
    check_val("rst_rreg2", 32'(bus.read_reg2), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Full dump with the sink always ready, plus latency checks
    rdy_mode = 0;
    clear_mon();
    base = done_count;
    pulse_start(rc);
    check_val("t1_read_busy", 32'(busy), 32'd1);
    check_val("t1_read_valid", 32'(bus.out_valid), 32'd0);
    check_val("t1_read_rreg1", 32'(bus.read_reg1), 32'd0);
    check_val("t1_read_rreg2", 32'(bus.read_reg2), 32'd1);
    @(posedge CLK);
    #1;
    check_val("t1_first_valid", 32'(bus.out_valid), 32'd1);
    check_val("t1_first_index", 32'(bus.out_index), 32'd0);
    wait_done("t1", base);
    check_val("t1_done_latency", 32'(done_cyc - rc), 32'(DONE_LAT));
    @(posedge CLK);
    #1;
    check_val("t1_idle_busy", 32'(busy), 32'd0);
    check_val("t1_idle_done", 32'(done), 32'd0);
    verify_dump("t1");

    // Ready toggling every cycle
    rdy_mode = 1;
    clear_mon();
    base = done_count;
    pulse_start(rc);
    wait_done("t2", base);
    repeat (3) @(posedge CLK);
    check_val("t2_one_done", 32'(done_count - base), 32'd1);
    verify_dump("t2");

    // start re-asserted mid-dump is ignored
    rdy_mode = 0;
    clear_mon();
    base = done_count;
    pulse_start(rc);
    wait_beats(5);
    pulse_start(rc);
    wait_beats(20);
    pulse_start(rc);
    wait_done("t3", base);
    repeat (20) @(posedge CLK);
    check_val("t3_one_done", 32'(done_count - base), 32'd1);
    check_val("t3_busy_after", 32'(busy), 32'd0);
    verify_dump("t3");

    // Reset while beat 13 is stalled
    rdy_mode = 2;
    clear_mon();
    base = done_count;
    pulse_start(rc);
    for (int i = 0; i < 500 && !(bus.out_valid && bus.out_index == 5'd13 && !bus.out_ready); i++)
      @(negedge CLK);
    check_val("t4_stall13_reached", 32'(bus.out_valid && bus.out_index == 5'd13), 32'd1);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check_val("t4_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("t4_rst_busy", 32'(busy), 32'd0);
    check_val("t4_rst_index", 32'(bus.out_index), 32'd0);
    check_val("t4_rst_rreg1", 32'(bus.read_reg1), 32'd0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    rdy_mode = 0;
    repeat (3) @(posedge CLK);
    check_val("t4_no_done", 32'(done_count - base), 32'd0);
    clear_mon();
    pulse_start(rc);
    wait_done("t4", base);
    verify_dump("t4");

    // Register write after READ of pair 2 must not reach beat 4
    rdy_mode = 0;
    clear_mon();
    base = done_count;
    pulse_start(rc);
    for (int i = 0; i < 200 && !(busy && !bus.out_valid && bus.read_reg1 == 5'd4); i++)
      @(negedge CLK);
    check_val("t5_read_pair2", 32'(bus.read_reg1), 32'd4);
    @(posedge CLK);
    #1 regs[4] = 32'hDEADBEEF;
    wait_done("t5", base);
    check_val("t5_beat4_old", (mon_data.size() > 4) ? mon_data[4] : 32'hFFFFFFFF, 32'h44444444);
    verify_dump("t5");
    regs[4] = exp_regs[4];

`ifdef REG_DUMP_CHECKSUM_EN
    // Checksum beat over a sparse register file
    for (int i = 0; i < 32; i++) begin
      regs[i]     = '0;
      exp_regs[i] = '0;
    end
    regs[20] = 32'h20000003; exp_regs[20] = 32'h20000003;
    regs[25] = 32'h3000000F; exp_regs[25] = 32'h3000000F;
    clear_mon();
    base = done_count;
    pulse_start(rc);
    wait_done("t6", base);
    check_val("t6_csum_data", (mon_data.size() == 33) ? mon_data[32] : 32'hFFFFFFFF, 32'h1000000C);
    check_val("t6_csum_index", (mon_idx.size() == 33) ? 32'(mon_idx[32]) : 32'hFF, 32'd0);
    check_val("t6_csum_last", (mon_last.size() == 33) ? 32'(mon_last[32]) : 32'hFF, 32'd1);
    verify_dump("t6");
`endif

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
